// File: rtl/task1_rom.sv
// task1_rom: read-only program memory holding the fixed Task 1 program for the
// 10-bit single-cycle CPU. It has 2**ADDR_W words of DATA_W bits and is indexed
// directly by the program counter.
//
// Ports:
//   clk       in   system clock, used only in registered-output mode
//   rst_n     in   asynchronous active-low reset, used only in registered-output mode
//   address   in   word address (PC value)
//   read_data out  instruction word at address
//
// Build option:
//   TASK1_ROM_REG_OUT_EN  When defined, read_data is registered: one cycle of
//                         latency, and reset forces NOP. When undefined, the read
//                         is purely combinational with zero latency.
//
// Contents are fixed at elaboration and are not affected by reset. Every location
// past the program reads as NOP (all zeros).

`timescale 1ns/1ps

module task1_rom #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] read_data
);

    localparam logic [DATA_W-1:0] Nop = '0;

    // Decoded ROM word for the current address. Addresses outside the program
    // fall through to the default, so no location is ever uninitialised.
    logic [DATA_W-1:0] rom_word;

    always_comb begin
        rom_word = Nop;
        case (address)
            ADDR_W'(0): rom_word = DATA_W'(10'b1100010000); // load s0, 0(t0)
            ADDR_W'(1): rom_word = DATA_W'(10'b0000101101); // sub t3, t3, t3
            ADDR_W'(2): rom_word = DATA_W'(10'b0111010101); // addi s2, s2, 1
            ADDR_W'(3): rom_word = DATA_W'(10'b1101001000); // load t1, 0(s0) (loop head)
            ADDR_W'(4): rom_word = DATA_W'(10'b0111010001); // addi s0, s0, 1
            ADDR_W'(5): rom_word = DATA_W'(10'b0111010111); // addi s2, s2, -1
            ADDR_W'(6): rom_word = DATA_W'(10'b1011001110); // beq t3, s2, +2 (to word 8)
            ADDR_W'(7): rom_word = DATA_W'(10'b1000000011); // jump to word 3
            ADDR_W'(8): rom_word = DATA_W'(10'b0010000010); // halt
            default:    rom_word = Nop;
        endcase
    end

`ifdef TASK1_ROM_REG_OUT_EN

    logic [DATA_W-1:0] read_data_q;

    // The asynchronous reset forces NOP immediately, so a CPU held in reset
    // never sees a stale instruction word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q <= Nop;
        end else begin
            read_data_q <= rom_word;
        end
    end

    assign read_data = read_data_q;

`else

    // clk and rst_n remain on the port list so both build options share one
    // footprint. This mode does not use them.
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst_n;

    assign read_data = rom_word;

`endif

endmodule

// File: tb/tb_task1_rom.sv
// tb_task1_rom: self-checking bench for task1_rom. It runs a fixed vector table, a
// full address sweep and random reads against a golden program image. It also runs
// mode-specific reset sequences for the combinational or registered build.

`timescale 1ns/1ps

module tb_task1_rom;

    logic       clk;
    logic       rst_n;
    logic [9:0] address;
    logic [9:0] read_data;

    int n_tests;
    int n_fail;

    task1_rom #(
        .DATA_W(10),
        .ADDR_W(10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .read_data(read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden image: the nine program words, followed by NOP everywhere else.
    logic [9:0] prog [0:8];

    function automatic logic [9:0] golden(input int a);
        if (a >= 0 && a <= 8) return prog[a];
        return 10'b0;
    endfunction

    typedef struct {
        logic [9:0] addr;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [0:11];

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Present an address and return the word it produces. The combinational build
    // samples a short time later. The registered build samples after one rising edge.
    task automatic read_word(input logic [9:0] a, output logic [9:0] d);
        @(negedge clk);
        address = a;
`ifdef TASK1_ROM_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #2;
`endif
        d = read_data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] d;
        int         a;

        n_tests = 0;
        n_fail  = 0;

        prog[0] = 10'b1100010000;
        prog[1] = 10'b0000101101;
        prog[2] = 10'b0111010101;
        prog[3] = 10'b1101001000;
        prog[4] = 10'b0111010001;
        prog[5] = 10'b0111010111;
        prog[6] = 10'b1011001110;
        prog[7] = 10'b1000000011;
        prog[8] = 10'b0010000010;

        vecs[0]  = '{10'd0,    10'b1100010000};
        vecs[1]  = '{10'd1,    10'b0000101101};
        vecs[2]  = '{10'd2,    10'b0111010101};
        vecs[3]  = '{10'd3,    10'b1101001000};
        vecs[4]  = '{10'd4,    10'b0111010001};
        vecs[5]  = '{10'd5,    10'b0111010111};
        vecs[6]  = '{10'd6,    10'b1011001110};
        vecs[7]  = '{10'd7,    10'b1000000011};
        vecs[8]  = '{10'd8,    10'b0010000010};
        vecs[9]  = '{10'd9,    10'b0000000000};
        vecs[10] = '{10'd512,  10'b0000000000};
        vecs[11] = '{10'd1023, 10'b0000000000};

        address = 10'd0;

`ifdef TASK1_ROM_REG_OUT_EN
        // While rst_n is held low, the output is NOP, even across clock edges.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_hold", read_data, 10'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", read_data, 10'b0);
        @(posedge clk);
        #1;
        check("first_edge_addr0", read_data, 10'b1100010000);

        // A new address appears only after the next rising edge.
        @(negedge clk);
        address = 10'd6;
        #2;
        check("addr6_before_edge", read_data, 10'b1100010000);
        @(posedge clk);
        #1;
        check("addr6_after_edge", read_data, 10'b1011001110);

        // Dropping reset between edges clears the output at once.
        read_word(10'd2, d);
        check("pre_reset_word2", d, 10'b0111010101);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", read_data, 10'b0);
        @(posedge clk);
        #1;
        check("async_reset_held", read_data, 10'b0);
        @(negedge clk);
        rst_n = 1'b1;
`else
        rst_n = 1'b1;
        #10;
        check("comb_addr0", read_data, 10'b1100010000);
        // Toggling reset must not disturb the combinational output.
        rst_n = 1'b0;
        #1;
        check("comb_rst_low", read_data, 10'b1100010000);
        rst_n = 1'b1;
        #1;
        check("comb_rst_high", read_data, 10'b1100010000);
        // The new word appears with zero latency, without a clock edge.
        address = 10'd8;
        #1;
        check("comb_zero_latency", read_data, 10'b0010000010);
`endif

        // Fixed vector table.
        for (int i = 0; i < 12; i++) begin
            read_word(vecs[i].addr, d);
            check($sformatf("vec_addr%0d", vecs[i].addr), d, vecs[i].exp);
        end

        // Full sweep against the golden image.
        for (int i = 0; i < 1024; i++) begin
            read_word(10'(i), d);
            check($sformatf("sweep_addr%0d", i), d, golden(i));
        end

        // Random reads. The address is biased toward the program region.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 0) a = int'($urandom_range(0, 15));
            else a = int'($urandom_range(0, 1023));
            read_word(10'(a), d);
            check($sformatf("rand_addr%0d", a), d, golden(a));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/task1_rom.md
Name: task1_rom

Overview:
- Read-only program memory holding the fixed Task 1 machine-code program for the team's 10-bit single-cycle CPU.
- 1024 words x 10 bits, indexed directly by the CPU program counter; the instruction word feeds the decoder.
- Asynchronous (combinational) read by default; an optional registered-output mode for pipelined integration.

Parameters:
- DATA_W, 10, instruction word width in bits.
- ADDR_W, 10, address width; depth = 2**ADDR_W = 1024 words.

Ports:
- clk  input  1  system clock; used only in registered-output mode.
- rst_n  input  1  asynchronous, active-low reset; used only in registered-output mode.
- address  input  ADDR_W  word address (PC value).
- read_data  output  DATA_W  instruction word at address.

Behaviour:
- Contents are fixed at elaboration; no write port; contents are not affected by reset.
- Program image, binary (mnemonic):
  - 0: 1100010000 (load s0, 0(t0))
  - 1: 0000101101 (sub t3, t3, t3; clears compare register)
  - 2: 0111010101 (addi s2, s2, 1)
  - 3: 1101001000 (load t1, 0(s0); loop)
  - 4: 0111010001 (addi s0, s0, 1)
  - 5: 0111010111 (addi s2, s2, -1)
  - 6: 1011001110 (beq t3, s2, +2 to word 8)
  - 7: 1000000011 (jump to word 3)
  - 8: 0010000010 (halt)
- All words 9..1023 read 0000000000 (NOP). There are no uninitialised locations.
- Default (combinational) mode:
  - read_data = mem[address], purely combinational, zero-cycle latency.
  - Output settles within the same cycle the address changes.
  - clk and rst_n are ignored; no reset value applies.
- Address is full-range (10 bits), so there is no out-of-range case and no wrap handling.
- An X/Z address gives don't-care output. The bench must not check it.
- Output never glitches to a non-table value for a stable, known address.

Optional Feature:
- Macro: TASK1_ROM_REG_OUT_EN.
- Defined:
  - read_data is a register loaded with mem[address] on each rising edge of clk. Latency is 1 cycle.
  - rst_n low asynchronously forces read_data to 0000000000 (NOP) and holds it while low.
  - On the first rising edge after rst_n deasserts, read_data loads mem[address].
  - Reset asserted mid-stream overrides immediately, regardless of clk.
- Undefined: combinational mode as above. clk and rst_n remain ports but are unused.

Test Plan:
- Combinational mode: address=0, wait 10 ns -> read_data=1100010000; address=1 -> 0000101101; address=2 -> 0111010101.
- Combinational mode: sweep addresses 3..8 -> match table, including 8 -> 0010000010 (halt) and 7 -> 1000000011.
- Combinational mode: addresses 9, 512, 1023 -> 0000000000. Toggling rst_n low then high with address=0 -> read_data stays 1100010000.
- Full sweep 0..1023 in either mode -> every word equals the golden image.
- TASK1_ROM_REG_OUT_EN: hold rst_n=0 with address=0 -> read_data=0. Release rst_n, then one rising edge -> 1100010000. Change address to 6 -> 1011001110 appears only after the next rising edge.
- TASK1_ROM_REG_OUT_EN: drop rst_n between edges while read_data=0111010101 -> read_data=0 immediately, without waiting for a clock edge.
